vga_sync_gen: RTL and testbench

VGA raster timing generator for the text-mode display path. Counts pixel and line positions, decodes the active-video window and the horizontal/vertical sync pulses, and drives the 10-bit `x`/`y` pixel coordinates that the character-position stage splits into character cell and in-cell offset. Sits directly upstream of that stage and drives the monitor's HS/VS pins.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_axis_cnt.sv | 59 +++++
 rtl/vga_sync_gen.sv | 110 +++++++++++
 tb/tb_vga_sync_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA raster generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Pixels per line including blanking.
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame including blanking.
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with active-window and sync
// decode. The decodes are computed from the next count so the registered
// sync flag lines up with the registered count in the same cycle.
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int TOTAL    = 800,
    parameter int ACTIVE   = 640,
    parameter int SYNC_BEG = 656,
    parameter int SYNC_END = 751,
    parameter bit POL      = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    output logic [COORD_W-1:0] cnt_o,
    output logic               wrap_o,
    output logic               active_nxt_o,
    output logic               sync_o
);

    // One extra bit so an edge value of 1024 does not alias to 0.
    localparam logic [COORD_W:0] LAST  = (COORD_W+1)'(TOTAL - 1);
    localparam logic [COORD_W:0] ACT   = (COORD_W+1)'(ACTIVE);
    localparam logic [COORD_W:0] S_BEG = (COORD_W+1)'(SYNC_BEG);
    localparam logic [COORD_W:0] S_END = (COORD_W+1)'(SYNC_END);

    logic [COORD_W-1:0] cnt_q, cnt_d;
    logic               sync_q, sync_d;
    logic               at_last;

    assign at_last = ({1'b0, cnt_q} == LAST);
    assign wrap_o  = en_i & at_last;

    // Next count and decodes of that next position.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
        active_nxt_o = ({1'b0, cnt_d} < ACT);
        sync_d       = (({1'b0, cnt_d} >= S_BEG) && ({1'b0, cnt_d} <= S_END)) ? POL : ~POL;
    end

    // Reset parks the counter on its last position, outside sync.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= COORD_W'(TOTAL - 1);
            sync_q <= ~POL;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign sync_o = sync_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, active-video window,
// HS/VS pulses and line/frame start strobes, all registered and aligned.
// Optional macro VGA_PIX_DIV2_EN: pixel rate is clk/2 via an internal toggle.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic               pix_stb
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must both be <= 1024");
    end

    logic pix_en;
    logic h_wrap, v_wrap;
    logic h_act_nxt, v_act_nxt;
    logic video_on_q, line_start_q, frame_start_q, pix_stb_q;

`ifdef VGA_PIX_DIV2_EN
    logic div_q;

    // Toggle flop: enable on every other clk, starting with the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= 1'b0;
        else     div_q <= ~div_q;
    end

    assign pix_en = ~div_q;
`else
    assign pix_en = 1'b1;
`endif

    vga_axis_cnt #(
        .TOTAL    (H_TOTAL),
        .ACTIVE   (H_ACTIVE),
        .SYNC_BEG (H_ACTIVE + H_FP),
        .SYNC_END (H_ACTIVE + H_FP + H_SYNC - 1),
        .POL      (HS_POL)
    ) u_h (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (pix_en),
        .cnt_o        (x),
        .wrap_o       (h_wrap),
        .active_nxt_o (h_act_nxt),
        .sync_o       (hsync)
    );

    // Vertical axis steps only when the line wraps.
    vga_axis_cnt #(
        .TOTAL    (V_TOTAL),
        .ACTIVE   (V_ACTIVE),
        .SYNC_BEG (V_ACTIVE + V_FP),
        .SYNC_END (V_ACTIVE + V_FP + V_SYNC - 1),
        .POL      (VS_POL)
    ) u_v (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (h_wrap),
        .cnt_o        (y),
        .wrap_o       (v_wrap),
        .active_nxt_o (v_act_nxt),
        .sync_o       (vsync)
    );

    // Registered window and strobes; strobes last exactly one clk because
    // the wrap terms are qualified by the pixel enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pix_stb_q     <= 1'b0;
        end else begin
            video_on_q    <= h_act_nxt & v_act_nxt;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            pix_stb_q     <= pix_en;
        end
    end

    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign pix_stb     = pix_stb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a small
// positive-polarity instance, both checked every cycle against a
// position-from-pixel-count reference, plus a constant vector table,
// period/width measurements and asynchronous reset sequences.
module tb_vga_sync_gen;

`ifdef VGA_PIX_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // Small geometry for the second instance: 25 x 14, frame of 350 pixels.
    localparam int BHA = 16, BHF = 2, BHS = 3, BHB = 4;
    localparam int BVA = 8,  BVF = 1, BVS = 2, BVB = 3;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic       stb;
    } obs_t;

    typedef struct {
        int k;    // pixel advances since reset release
        int x;
        int y;
        bit von;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [9:0] xa, ya, xb, yb;
    logic von_a, hs_a, vs_a, ls_a, fs_a, stb_a;
    logic von_b, hs_b, vs_b, ls_b, fs_b, stb_b;

    int checks = 0;
    int errors = 0;
    int c = 0;
    bit tbl_on = 1'b0;
    int last_ls_a, hs_cnt_a, last_fs_b, vs_cnt_b;

    vec_t vec [11];

    always #5 clk = ~clk;

    vga_sync_gen dut_a (
        .clk(clk), .rst(rst), .x(xa), .y(ya), .video_on(von_a), .hsync(hs_a),
        .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a), .pix_stb(stb_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .x(xb), .y(yb), .video_on(von_b), .hsync(hs_b),
        .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b), .pix_stb(stb_b)
    );

    // Expected outputs cyc clock edges after reset release (cyc=0: in reset).
    function automatic obs_t model(int cyc, int ha, int hf, int hsy, int hb,
                                   int va, int vf, int vsy, int vb, bit hp, bit vp);
        obs_t m;
        int ht, vt, k, p, xx, yy;
        bit adv;
        ht  = ha + hf + hsy + hb;
        vt  = va + vf + vsy + vb;
        k   = (DIV == 1) ? cyc : (cyc + 1) / 2;
        adv = (cyc >= 1) && ((DIV == 1) || (cyc % 2 == 1));
        if (k == 0) begin
            xx = ht - 1;
            yy = vt - 1;
        end else begin
            p  = (k - 1) % (ht * vt);
            xx = p % ht;
            yy = p / ht;
        end
        m.x   = 10'(xx);
        m.y   = 10'(yy);
        m.von = (k >= 1) && (xx < ha) && (yy < va);
        m.hs  = (xx >= ha + hf && xx < ha + hf + hsy) ? hp : !hp;
        m.vs  = (yy >= va + vf && yy < va + vf + vsy) ? vp : !vp;
        m.ls  = adv && (xx == 0);
        m.fs  = adv && (xx == 0) && (yy == 0);
        m.stb = adv;
        return m;
    endfunction

    function automatic obs_t model_a(int cyc);
        return model(cyc, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction

    function automatic obs_t model_b(int cyc);
        return model(cyc, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b1, 1'b1);
    endfunction

    function automatic obs_t act_a();
        return '{x: xa, y: ya, von: von_a, hs: hs_a, vs: vs_a, ls: ls_a, fs: fs_a, stb: stb_a};
    endfunction

    function automatic obs_t act_b();
        return '{x: xb, y: yb, von: von_b, hs: hs_b, vs: vs_b, ls: ls_b, fs: fs_b, stb: stb_b};
    endfunction

    function automatic int tcyc(int k);
        return (DIV == 1) ? k : 2 * k - 1;
    endfunction

    task automatic cmp(input string nm, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s c=%0d got x=%0d y=%0d von=%b hs=%b vs=%b ls=%b fs=%b stb=%b want x=%0d y=%0d von=%b hs=%b vs=%b ls=%b fs=%b stb=%b",
                     nm, c, act.x, act.y, act.von, act.hs, act.vs, act.ls, act.fs, act.stb,
                     exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.ls, exp.fs, exp.stb);
        end
    endtask

    task automatic cmp_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s c=%0d got %0d want %0d", nm, c, act, exp);
        end
    endtask

    task automatic check_vec(input int t);
        obs_t e;
        e = '{x: 10'(vec[t].x), y: 10'(vec[t].y), von: vec[t].von, hs: vec[t].hs,
              vs: vec[t].vs, ls: vec[t].ls, fs: vec[t].fs, stb: (vec[t].k > 0)};
        cmp($sformatf("vec%0d_k%0d", t, vec[t].k), act_a(), e);
    endtask

    task automatic clear_trackers();
        last_ls_a = -1;
        hs_cnt_a  = 0;
        last_fs_b = -1;
        vs_cnt_b  = 0;
    endtask

    // Advance one clk and check everything at the following falling edge.
    task automatic step();
        @(posedge clk);
        c++;
        @(negedge clk);
        cmp("model_a", act_a(), model_a(c));
        cmp("model_b", act_b(), model_b(c));
        if (tbl_on) begin
            for (int t = 0; t < 11; t++) begin
                if (vec[t].k > 0 && tcyc(vec[t].k) == c) check_vec(t);
            end
        end
        if (hs_a == 1'b0) hs_cnt_a++;
        if (ls_a) begin
            if (last_ls_a >= 0) begin
                cmp_int("line_period_a", c - last_ls_a, 800 * DIV);
                cmp_int("hsync_width_a", hs_cnt_a, 96 * DIV);
            end
            last_ls_a = c;
            hs_cnt_a  = 0;
        end
        if (vs_b == 1'b1) vs_cnt_b++;
        if (fs_b) begin
            if (last_fs_b >= 0) begin
                cmp_int("frame_period_b", c - last_fs_b, 350 * DIV);
                cmp_int("vsync_width_b", vs_cnt_b, 2 * 25 * DIV);
            end
            last_fs_b = c;
            vs_cnt_b  = 0;
        end
    endtask

    task automatic scan(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called just after a falling-edge sample; asserts reset between edges.
    task automatic async_reset(input int dly);
        #(dly);
        rst = 1'b1;
        #1;
        cmp("async_rst_a", act_a(), model_a(0));
        cmp("async_rst_b", act_b(), model_b(0));
        repeat (3) @(negedge clk);
        cmp("held_rst_a", act_a(), model_a(0));
        cmp("held_rst_b", act_b(), model_b(0));
        rst = 1'b0;
        c   = 0;
        clear_trackers();
    endtask

    initial begin
        bit hit;
        vec[0]  = '{k: 0,    x: 799, y: 524, von: 0, hs: 1, vs: 1, ls: 0, fs: 0};
        vec[1]  = '{k: 1,    x: 0,   y: 0,   von: 1, hs: 1, vs: 1, ls: 1, fs: 1};
        vec[2]  = '{k: 640,  x: 639, y: 0,   von: 1, hs: 1, vs: 1, ls: 0, fs: 0};
        vec[3]  = '{k: 641,  x: 640, y: 0,   von: 0, hs: 1, vs: 1, ls: 0, fs: 0};
        vec[4]  = '{k: 656,  x: 655, y: 0,   von: 0, hs: 1, vs: 1, ls: 0, fs: 0};
        vec[5]  = '{k: 657,  x: 656, y: 0,   von: 0, hs: 0, vs: 1, ls: 0, fs: 0};
        vec[6]  = '{k: 752,  x: 751, y: 0,   von: 0, hs: 0, vs: 1, ls: 0, fs: 0};
        vec[7]  = '{k: 753,  x: 752, y: 0,   von: 0, hs: 1, vs: 1, ls: 0, fs: 0};
        vec[8]  = '{k: 800,  x: 799, y: 0,   von: 0, hs: 1, vs: 1, ls: 0, fs: 0};
        vec[9]  = '{k: 801,  x: 0,   y: 1,   von: 1, hs: 1, vs: 1, ls: 1, fs: 0};
        vec[10] = '{k: 1441, x: 640, y: 1,   von: 0, hs: 1, vs: 1, ls: 0, fs: 0};

        rst = 1'b0;
        #1 rst = 1'b1;
        clear_trackers();
        repeat (3) @(negedge clk);
        check_vec(0);
        cmp("reset_b", act_b(), model_b(0));

        // Release and scan: table, several lines of dut_a, many frames of dut_b.
        rst = 1'b0;
        c = 0;
        tbl_on = 1'b1;
        scan(3000);
        tbl_on = 1'b0;

        // Move dut_b into the middle of its frame and reset between edges.
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            step();
            if (xb == 10'd10 && yb == 10'd5) hit = 1'b1;
        end
        cmp_int("reach_mid_frame_b", int'(hit), 1);
        async_reset(int'($urandom_range(0, 3)));
        scan(int'($urandom_range(1200, 2000)));

        // A second reset at a random point, then a clean restart.
        async_reset(int'($urandom_range(0, 3)));
        scan(int'($urandom_range(900, 1500)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
